// File: rtl/hazard_tracker_if.sv
// Issue/operand/hazard signal bundle between the ID stage and the hazard tracker.
interface hazard_tracker_if #(
  parameter int REG_IDX_W = 4,
  parameter int DEPTH     = 4,
  parameter int NUM_SRC   = 2,
  parameter int LAT_W     = 2,
  parameter int SEL_W     = $clog2(DEPTH + 1)
);
  logic                           issue_valid;
  logic                           issue_we;
  logic [REG_IDX_W-1:0]           issue_rd;
  logic [LAT_W-1:0]               issue_lat;
  logic [NUM_SRC*REG_IDX_W-1:0]   src_idx;
  logic [NUM_SRC-1:0]             src_used;
  logic                           flush;
  logic                           stall;
  logic [NUM_SRC*SEL_W-1:0]       fwd_sel;
  logic [SEL_W-1:0]               inflight_count;

  // ID stage side: presents the instruction, consumes stall/forward selects.
  modport master (
    output issue_valid, issue_we, issue_rd, issue_lat, src_idx, src_used, flush,
    input  stall, fwd_sel, inflight_count
  );

  // Tracker side.
  modport slave (
    input  issue_valid, issue_we, issue_rd, issue_lat, src_idx, src_used, flush,
    output stall, fwd_sel, inflight_count
  );
endinterface

// File: rtl/hazard_tracker.sv
// Hazard detection and forwarding-select generation for an in-order pipeline.
// Each issued writer is followed through DEPTH stages with a countdown until
// its result becomes forwardable; stall and fwd_sel derive from that state.
module hazard_tracker #(
  parameter int REG_IDX_W  = 4,
  parameter int DEPTH      = 4,
  parameter int NUM_SRC    = 2,
  parameter int LAT_W      = 2,
  parameter int KILL_DEPTH = 1,
  parameter int SEL_W      = $clog2(DEPTH + 1)
) (
  input logic            clk,
  input logic            rst,
  hazard_tracker_if.slave bus
);

  logic [DEPTH-1:0]     ent_vld;
  logic [REG_IDX_W-1:0] ent_rd  [DEPTH];
  logic [LAT_W-1:0]     ent_rem [DEPTH];

  logic [DEPTH-1:0]     nxt_vld;
  logic [REG_IDX_W-1:0] nxt_rd  [DEPTH];
  logic [LAT_W-1:0]     nxt_rem [DEPTH];

  logic [SEL_W-1:0]         cnt_q;
  logic [NUM_SRC-1:0]       src_stall;
  logic [NUM_SRC*SEL_W-1:0] fwd_sel_c;
  logic                     accept;

  // Countdown step that holds at zero once the result is forwardable.
  function automatic logic [LAT_W-1:0] sat_dec(input logic [LAT_W-1:0] x);
    return (x == '0) ? x : x - 1'b1;
  endfunction

  function automatic logic [SEL_W-1:0] popcount(input logic [DEPTH-1:0] v);
    logic [SEL_W-1:0] c;
    c = '0;
    for (int i = 0; i < DEPTH; i++) c = c + SEL_W'(v[i]);
    return c;
  endfunction

  // Per-source match: scan oldest to youngest so the youngest match wins.
  always_comb begin
    src_stall = '0;
    fwd_sel_c = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (bus.src_used[s] &&
            (bus.src_idx[s*REG_IDX_W +: REG_IDX_W] != '0) &&
            ent_vld[i] &&
            (ent_rd[i] == bus.src_idx[s*REG_IDX_W +: REG_IDX_W])) begin
          fwd_sel_c[s*SEL_W +: SEL_W] = SEL_W'(i + 1);
          src_stall[s]                = (ent_rem[i] != '0);
        end
      end
    end
  end

  assign bus.stall          = |src_stall;
  assign bus.fwd_sel        = fwd_sel_c;
  assign bus.inflight_count = cnt_q;

  // x0 writes and dropped/stalled/flushed instructions enter as bubbles.
  assign accept = bus.issue_valid & ~bus.stall & ~bus.flush & bus.issue_we &
                  (bus.issue_rd != '0);

  // Next state: new entry at 0, shift older ones down, kill the youngest on flush.
  always_comb begin
    nxt_vld    = '0;
    nxt_vld[0] = accept;
    nxt_rd[0]  = bus.issue_rd;
    nxt_rem[0] = bus.issue_lat;
    for (int i = 1; i < DEPTH; i++) begin
      nxt_vld[i] = ent_vld[i-1] & ~(bus.flush && ((i - 1) < KILL_DEPTH));
      nxt_rd[i]  = ent_rd[i-1];
      nxt_rem[i] = sat_dec(ent_rem[i-1]);
    end
  end

  // Entry shift register and registered occupancy count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_vld <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_rd[i]  <= '0;
        ent_rem[i] <= '0;
      end
    end else begin
      ent_vld <= nxt_vld;
      cnt_q   <= popcount(nxt_vld);
      for (int i = 0; i < DEPTH; i++) begin
        ent_rd[i]  <= nxt_rd[i];
        ent_rem[i] <= nxt_rem[i];
      end
    end
  end

endmodule

// File: tb/tb_hazard_tracker.sv
// Directed scenario bench for hazard_tracker.
module tb_hazard_tracker;
  localparam int RW = 4;
  localparam int DP = 4;
  localparam int NS = 2;
  localparam int LW = 2;
  localparam int KD = 1;
  localparam int SW = $clog2(DP + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  hazard_tracker_if #(.REG_IDX_W(RW), .DEPTH(DP), .NUM_SRC(NS), .LAT_W(LW), .SEL_W(SW)) bus();

  hazard_tracker #(.REG_IDX_W(RW), .DEPTH(DP), .NUM_SRC(NS), .LAT_W(LW),
                   .KILL_DEPTH(KD), .SEL_W(SW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always @(posedge clk)
    if (!rst && bus.issue_valid)
      assert (int'(bus.issue_lat) < DP) else $error("issue_lat out of range");

  function automatic logic [SW-1:0] fsel(input int s);
    return bus.fwd_sel[s*SW +: SW];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.issue_valid = 1'b0;
    bus.issue_we    = 1'b0;
    bus.issue_rd    = '0;
    bus.issue_lat   = '0;
    bus.src_idx     = '0;
    bus.src_used    = '0;
    bus.flush       = 1'b0;
  endtask

  task automatic issue(input logic [RW-1:0] rd, input logic [LW-1:0] lat);
    bus.issue_valid = 1'b1;
    bus.issue_we    = 1'b1;
    bus.issue_rd    = rd;
    bus.issue_lat   = lat;
  endtask

  task automatic set_src(input int s, input logic [RW-1:0] idx, input logic used);
    bus.src_idx[s*RW +: RW] = idx;
    bus.src_used[s]         = used;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    issue(4'd1, 2'd3);                 // c0
    tick(); issue(4'd2, 2'd3);         // c1
    tick(); issue(4'd3, 2'd3);         // c2
    tick(); idle();                    // c3
    set_src(0, 4'd3, 1'b1);
    set_src(1, 4'd1, 1'b1);
    #2;
    tests++; if (bus.stall !== 1'b1) begin fails++; $display("FAIL pre_reset_stall got=%0b want=1", bus.stall); end
    tests++; if (bus.inflight_count !== 3'd3) begin fails++; $display("FAIL pre_reset_count got=%0d want=3", bus.inflight_count); end
    #1 rst = 1'b1;
    #1;
    tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL async_reset_stall got=%0b want=0", bus.stall); end
    tests++; if (bus.fwd_sel !== '0) begin fails++; $display("FAIL async_reset_fwd got=%0h want=0", bus.fwd_sel); end
    tests++; if (bus.inflight_count !== 3'd0) begin fails++; $display("FAIL async_reset_count got=%0d want=0", bus.inflight_count); end
    #1 rst = 1'b0;
    tick();
    tests++; if (bus.fwd_sel !== '0 || bus.stall !== 1'b0) begin fails++; $display("FAIL post_reset_sel got=%0h stall=%0b want=0", bus.fwd_sel, bus.stall); end
    tests++; if (bus.inflight_count !== 3'd0) begin fails++; $display("FAIL post_reset_count got=%0d want=0", bus.inflight_count); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    issue(4'd5, 2'd0); #2;             // c0
    tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL b2b_c0_stall got=%0b want=0", bus.stall); end
    tick(); idle(); set_src(0, 4'd5, 1'b1); #2;   // c1
    tests++; if (bus.stall !== 1'b0 || fsel(0) !== 3'd1) begin fails++; $display("FAIL b2b_c1 stall=%0b sel=%0d want 0/1", bus.stall, fsel(0)); end
    tick(); #2;                        // c2
    tests++; if (bus.stall !== 1'b0 || fsel(0) !== 3'd2) begin fails++; $display("FAIL b2b_c2 stall=%0b sel=%0d want 0/2", bus.stall, fsel(0)); end
    do_reset();
    issue(4'd5, 2'd0);                 // c0
    tick(); issue(4'd6, 2'd0);         // c1
    tick(); idle(); set_src(0, 4'd5, 1'b1); set_src(1, 4'd6, 1'b1); #2;  // c2
    tests++; if (fsel(0) !== 3'd2 || fsel(1) !== 3'd1 || bus.stall !== 1'b0) begin fails++; $display("FAIL b2b_two_src sel0=%0d sel1=%0d stall=%0b want 2/1/0", fsel(0), fsel(1), bus.stall); end
  endtask

  task automatic test_load_use();
    do_reset();
    issue(4'd7, 2'd2);                 // c0
    tick(); issue(4'd8, 2'd0); set_src(1, 4'd7, 1'b1); #2;   // c1
    tests++; if (bus.stall !== 1'b1) begin fails++; $display("FAIL lu_c1_stall got=%0b want=1", bus.stall); end
    tick(); #2;                        // c2
    tests++; if (bus.stall !== 1'b1) begin fails++; $display("FAIL lu_c2_stall got=%0b want=1", bus.stall); end
    tick(); #2;                        // c3
    tests++; if (bus.stall !== 1'b0 || fsel(1) !== 3'd3) begin fails++; $display("FAIL lu_c3 stall=%0b sel=%0d want 0/3", bus.stall, fsel(1)); end
    tests++; if (bus.inflight_count !== 3'd1) begin fails++; $display("FAIL lu_c3_count got=%0d want=1", bus.inflight_count); end
    tick(); idle(); #2;                // c4
    tests++; if (bus.inflight_count !== 3'd2) begin fails++; $display("FAIL lu_c4_count got=%0d want=2", bus.inflight_count); end
  endtask

  task automatic test_youngest();
    do_reset();
    issue(4'd3, 2'd0);                 // c0
    tick(); issue(4'd3, 2'd1);         // c1
    tick(); idle(); set_src(0, 4'd3, 1'b1); #2;  // c2
    tests++; if (bus.stall !== 1'b1 || fsel(0) !== 3'd1) begin fails++; $display("FAIL young_c2 stall=%0b sel=%0d want 1/1", bus.stall, fsel(0)); end
    tick(); #2;                        // c3
    tests++; if (bus.stall !== 1'b0 || fsel(0) !== 3'd2) begin fails++; $display("FAIL young_c3 stall=%0b sel=%0d want 0/2", bus.stall, fsel(0)); end
  endtask

  task automatic test_x0_unused();
    do_reset();
    issue(4'd0, 2'd0);                 // c0
    tick(); issue(4'd6, 2'd1); #2;     // c1
    tests++; if (bus.inflight_count !== 3'd0) begin fails++; $display("FAIL x0_count got=%0d want=0", bus.inflight_count); end
    tick(); idle(); set_src(0, 4'd0, 1'b1); set_src(1, 4'd6, 1'b0); #2;  // c2
    tests++; if (bus.inflight_count !== 3'd1) begin fails++; $display("FAIL x0_c2_count got=%0d want=1", bus.inflight_count); end
    tests++; if (bus.stall !== 1'b0 || bus.fwd_sel !== '0) begin fails++; $display("FAIL unused_src stall=%0b sel=%0h want 0/0", bus.stall, bus.fwd_sel); end
    set_src(1, 4'd6, 1'b1); #1;
    tests++; if (bus.stall !== 1'b1 || fsel(1) !== 3'd1) begin fails++; $display("FAIL used_src stall=%0b sel=%0d want 1/1", bus.stall, fsel(1)); end
  endtask

  task automatic test_flush();
    do_reset();
    issue(4'd9, 2'd0);                 // c0
    tick(); issue(4'd10, 2'd0); bus.flush = 1'b1;  // c1
    tick(); idle(); set_src(0, 4'd9, 1'b1); set_src(1, 4'd10, 1'b1); #2;  // c2
    tests++; if (bus.fwd_sel !== '0) begin fails++; $display("FAIL flush_sel got=%0h want=0", bus.fwd_sel); end
    tests++; if (bus.inflight_count !== 3'd0) begin fails++; $display("FAIL flush_count got=%0d want=0", bus.inflight_count); end
    do_reset();
    issue(4'd9, 2'd0);                 // c0
    tick(); issue(4'd11, 2'd0);        // c1
    tick(); issue(4'd14, 2'd0); bus.flush = 1'b1;  // c2
    tick(); idle(); set_src(0, 4'd9, 1'b1); set_src(1, 4'd11, 1'b1); #2;  // c3
    tests++; if (fsel(0) !== 3'd3 || fsel(1) !== 3'd0) begin fails++; $display("FAIL flush_older sel0=%0d sel1=%0d want 3/0", fsel(0), fsel(1)); end
    tests++; if (bus.inflight_count !== 3'd1) begin fails++; $display("FAIL flush_older_count got=%0d want=1", bus.inflight_count); end
    do_reset();
    issue(4'd12, 2'd3);                // c0
    tick(); issue(4'd13, 2'd0); set_src(0, 4'd12, 1'b1); bus.flush = 1'b1; #2;  // c1
    tests++; if (bus.stall !== 1'b1) begin fails++; $display("FAIL flush_stall_comb got=%0b want=1", bus.stall); end
    tick(); idle(); set_src(0, 4'd12, 1'b1); #2;   // c2
    tests++; if (bus.stall !== 1'b0 || bus.inflight_count !== 3'd0) begin fails++; $display("FAIL flush_over_stall stall=%0b count=%0d want 0/0", bus.stall, bus.inflight_count); end
  endtask

  task automatic test_drop_off();
    do_reset();
    issue(4'd4, 2'd0);                 // c0
    tick(); idle(); set_src(0, 4'd4, 1'b1);   // c1
    tick(); tick(); tick(); #2;        // c4
    tests++; if (fsel(0) !== 3'd4 || bus.inflight_count !== 3'd1) begin fails++; $display("FAIL drop_c4 sel=%0d count=%0d want 4/1", fsel(0), bus.inflight_count); end
    tick(); #2;                        // c5
    tests++; if (fsel(0) !== 3'd0 || bus.inflight_count !== 3'd0) begin fails++; $display("FAIL drop_c5 sel=%0d count=%0d want 0/0", fsel(0), bus.inflight_count); end
  endtask

  initial begin
    idle();
    test_reset();
    test_back_to_back();
    test_load_use();
    test_youngest();
    test_x0_unused();
    test_flush();
    test_drop_off();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
